dbus_arbiter: RTL

Shares the single SRAM-like data-cache port between two requesters: the AGU load path and the committed-store drain path. It grants one requester per address phase and holds the grant until the address phase completes. It tracks up to `MAX_OUTSTANDING` in-flight transactions in issue order, so each `dcache_data_ok` is routed back to its owner. On pipeline flush it silently discards pending load responses. It sits between the execute-stage AGU/store-drain logic and the dcache.

---
 rtl/dbus_arbiter_pkg.sv | 27 ++
 rtl/dbus_owner_fifo.sv | 87 ++++++++
 rtl/dbus_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dbus_arbiter_pkg
// Shared types for the data-bus arbiter slice.
//   uint32_t      : 32-bit bus word
//   dbus_owner_t  : which requester owns a dcache transaction (load / store)
//   arb_state_t   : address-phase FSM states
//   cnt_width()   : width needed to count 0..max_out in-flight transactions
// ---------------------------------------------------------------------------
package dbus_arbiter_pkg;

  typedef logic [31:0] uint32_t;

  typedef enum logic {
    DBUS_LD = 1'b0,
    DBUS_ST = 1'b1
  } dbus_owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/dbus_owner_fifo.sv
// ---------------------------------------------------------------------------
// dbus_owner_fifo
// In-order record of accepted dcache transactions so each response can be
// routed back to the requester that issued it.
// Ports:
//   clk, resetn              : clock, asynchronous active-low reset
//   push, push_owner,
//   push_killed              : append one entry {owner, killed}
//   pop                      : retire the head entry (ignored when empty)
//   kill_loads               : mark every stored load entry as killed
//   head_owner, head_killed  : current head entry
//   count                    : number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module dbus_owner_fifo
  import dbus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  dbus_owner_t                  push_owner,
  input  logic                         push_killed,
  input  logic                         pop,
  input  logic                         kill_loads,
  output dbus_owner_t                  head_owner,
  output logic                         head_killed,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  dbus_owner_t       owner_q  [DEPTH];
  logic              killed_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  // The arbiter never pushes into a full FIFO; the guard just keeps the
  // pointers consistent if that contract were ever broken.
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop  && (count != '0);

  assign head_owner  = owner_q[rd_ptr];
  assign head_killed = killed_q[rd_ptr];

  // Storage, pointers and occupancy. The bulk kill touches every slot; stale
  // slots are harmless because a push always rewrites both fields, and the
  // push assignment comes last so a freshly pushed entry keeps its own bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        owner_q[i]  <= DBUS_LD;
        killed_q[i] <= 1'b0;
      end
    end else begin
      if (kill_loads) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (owner_q[i] == DBUS_LD) begin
            killed_q[i] <= 1'b1;
          end
        end
      end
      if (do_push) begin
        owner_q[wr_ptr]  <= push_owner;
        killed_q[wr_ptr] <= push_killed;
        wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter
// Shares the SRAM-like dcache port between the AGU load path and the
// committed-store drain path. One requester is granted per address phase and
// the grant is held until the dcache accepts it. Accepted transactions are
// tracked in issue order so each dcache_data_ok returns to its owner; a
// pipeline flush silently drops outstanding load responses.
//
// Optional feature macro: DBUS_STARVE_GUARD_EN
//   defined   : after STARVE_LIMIT contended load grants, the next contended
//               arbitration goes to the store
//   undefined : strict load priority, no starvation counter
//
// Ports:
//   clk, resetn                       : clock, asynchronous active-low reset
//   flush                             : pipeline flush
//   ld_req/ld_addr -> ld_addr_ok      : load address phase
//   ld_data_ok/ld_rdata               : load response
//   st_req/st_addr/st_wstrb/st_wdata  : store address phase
//   st_addr_ok/st_data_ok             : store accept / write done
//   dcache_req/wr/wstrb/addr/wdata    : dcache request side
//   dcache_addr_ok/data_ok/rdata      : dcache handshake and read data
// ---------------------------------------------------------------------------
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        ld_req,
  input  uint32_t     ld_addr,
  output logic        ld_addr_ok,
  output logic        ld_data_ok,
  output uint32_t     ld_rdata,
  input  logic        st_req,
  input  uint32_t     st_addr,
  input  logic [3:0]  st_wstrb,
  input  uint32_t     st_wdata,
  output logic        st_addr_ok,
  output logic        st_data_ok,
  output logic        dcache_req,
  output logic        dcache_wr,
  output logic [3:0]  dcache_wstrb,
  output uint32_t     dcache_addr,
  output uint32_t     dcache_wdata,
  input  logic        dcache_addr_ok,
  input  logic        dcache_data_ok,
  input  uint32_t     dcache_rdata
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  arb_state_t   state;
  arb_state_t   next_state;
  logic [CNT_W-1:0] cnt;
  logic         full;
  logic         ld_live;
  logic         starve_force;

  logic         grant_valid;
  dbus_owner_t  grant_owner;
  logic         capture;
  logic         push;
  dbus_owner_t  push_owner;
  logic         push_killed;
  logic         resp_valid;

  dbus_owner_t  head_owner;
  logic         head_killed;

  dbus_owner_t  hold_owner;
  uint32_t      hold_addr;
  logic [3:0]   hold_wstrb;
  uint32_t      hold_wdata;
  logic         hold_killed;

  assign full    = (cnt == FULL_CNT);
  // A load requested in the flush cycle belongs to the squashed path.
  assign ld_live = ld_req && !flush;

  dbus_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_owner (push_owner),
    .push_killed(push_killed),
    .pop        (dcache_data_ok),
    .kill_loads (flush),
    .head_owner (head_owner),
    .head_killed(head_killed),
    .count      (cnt)
  );

`ifdef DBUS_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  logic [STARVE_W-1:0] starve_cnt;

  assign starve_force = (starve_cnt >= STARVE_MAX);

  // Counts load grants that overtook a waiting store; any store grant
  // resets it. Saturates so a long load burst cannot wrap it back to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (grant_valid) begin
      if (grant_owner == DBUS_ST) begin
        starve_cnt <= '0;
      end else if (st_req && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Address-phase FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Hold registers: snapshot of the winner's request when the dcache stalls,
  // so the address phase stays stable even if the requester's inputs move.
  // A flush during HOLD marks a held load so it retires as killed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_owner  <= DBUS_LD;
      hold_addr   <= '0;
      hold_wstrb  <= '0;
      hold_wdata  <= '0;
      hold_killed <= 1'b0;
    end else if (capture) begin
      hold_owner  <= grant_owner;
      hold_addr   <= dcache_addr;
      hold_wstrb  <= dcache_wstrb;
      hold_wdata  <= dcache_wdata;
      hold_killed <= 1'b0;
    end else if ((state == ARB_HOLD) && flush && (hold_owner == DBUS_LD)) begin
      hold_killed <= 1'b1;
    end
  end

  // Arbitration, dcache drive and acceptance. In IDLE the winner is decided
  // and presented combinationally, giving zero-cycle accept when the dcache
  // is ready; in HOLD only the snapshot is presented.
  always_comb begin
    next_state   = state;
    grant_valid  = 1'b0;
    grant_owner  = DBUS_LD;
    capture      = 1'b0;
    push         = 1'b0;
    push_owner   = DBUS_LD;
    push_killed  = 1'b0;
    dcache_req   = 1'b0;
    dcache_wr    = 1'b0;
    dcache_wstrb = '0;
    dcache_addr  = '0;
    dcache_wdata = '0;
    ld_addr_ok   = 1'b0;
    st_addr_ok   = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        if (!full && (ld_live || st_req)) begin
          grant_valid = 1'b1;
          // Load wins contention unless the starvation guard says the
          // store has waited long enough.
          if (ld_live && !(st_req && starve_force)) begin
            grant_owner = DBUS_LD;
            dcache_addr = ld_addr;
          end else begin
            grant_owner  = DBUS_ST;
            dcache_wr    = 1'b1;
            dcache_wstrb = st_wstrb;
            dcache_addr  = st_addr;
            dcache_wdata = st_wdata;
          end
          dcache_req = 1'b1;
          if (dcache_addr_ok) begin
            push       = 1'b1;
            push_owner = grant_owner;
            ld_addr_ok = (grant_owner == DBUS_LD);
            st_addr_ok = (grant_owner == DBUS_ST);
          end else begin
            capture    = 1'b1;
            next_state = ARB_HOLD;
          end
        end
      end

      ARB_HOLD: begin
        dcache_req   = 1'b1;
        dcache_wr    = (hold_owner == DBUS_ST);
        dcache_wstrb = hold_wstrb;
        dcache_addr  = hold_addr;
        dcache_wdata = hold_wdata;
        if (dcache_addr_ok) begin
          // The SRAM-like port forbids withdrawing a request, so a flushed
          // load still completes its address phase but is recorded as dead
          // and never acknowledged to the squashed pipeline.
          push        = 1'b1;
          push_owner  = hold_owner;
          push_killed = (hold_owner == DBUS_LD) && (hold_killed || flush);
          ld_addr_ok  = (hold_owner == DBUS_LD) && !push_killed;
          st_addr_ok  = (hold_owner == DBUS_ST);
          next_state  = ARB_IDLE;
        end
      end

      default: next_state = ARB_IDLE;
    endcase
  end

  // Response routing: the FIFO head names the owner. A response arriving in
  // the flush cycle itself is treated as already squashed.
  assign resp_valid = dcache_data_ok && (cnt != '0);
  assign st_data_ok = resp_valid && (head_owner == DBUS_ST);
  assign ld_data_ok = resp_valid && (head_owner == DBUS_LD) && !head_killed && !flush;
  assign ld_rdata   = ld_data_ok ? dcache_rdata : '0;

  // A response with nothing in flight means the dcache broke its contract.
  a_no_orphan_resp: assert property (
    @(posedge clk) disable iff (!resetn) dcache_data_ok |-> (cnt != '0)
  );

  // Parameter sanity: at least one slot and a non-zero starvation limit.
  a_param_range: assert property (
    @(posedge clk) (MAX_OUTSTANDING >= 1) && (STARVE_LIMIT >= 1)
  );

endmodule
